// File: rtl/lib_switch_allocator_onehot_pkg.sv
// Shared types and helpers for the one-hot switch allocator.
//   alloc_state_t : per-output lock state (idle / locked to an owner)
//   alloc_vec_t   : wide [0:MAX-1] vector, index 0 is the MSB, matching the
//                   [0:N-1] ordering of the crossbar select bus
//   onehot_to_bin / bin_to_onehot : index <-> one-hot conversion in that ordering
package lib_switch_allocator_onehot_pkg;

    localparam int unsigned ALLOC_MAX_N = 32;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_t;

    typedef logic [0:ALLOC_MAX_N-1] alloc_vec_t;

    // Expects at most one bit set; returns 0 for an all-zero vector.
    function automatic int unsigned onehot_to_bin(input alloc_vec_t vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ALLOC_MAX_N; i++) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

    function automatic alloc_vec_t bin_to_onehot(input int unsigned idx);
        alloc_vec_t vec;
        vec = '0;
        for (int unsigned i = 0; i < ALLOC_MAX_N; i++) begin
            vec[i] = (i == idx);
        end
        return vec;
    endfunction

endpackage

// File: rtl/lib_switch_allocator_onehot_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : [0:N-1] request vector
//   ptr : index with the highest priority this cycle
//   gnt : [0:N-1] one-hot grant, first requester at or after ptr, wrapping N-1 -> 0
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [0:N-1]  req,
    input  logic [PW-1:0] ptr,
    output logic [0:N-1]  gnt
);

    // Two passes: first the upper part [ptr..N-1], then the wrapped part [0..ptr-1].
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lib_switch_allocator_onehot.sv
// Per-output one-hot input-select generator for an NxM one-hot crossbar.
// Each output has a round-robin arbiter and a lock FSM; a granted input keeps
// the output until it sends its tail word or stops requesting that output.
//   clk, reset_n : clock, async active-low reset
//   ce           : clock enable, all state frozen when low
//   i_req        : [0:N-1][0:M-1] request of input n for output m
//   i_tail       : [0:N-1] input n's current word is its packet's last word
//   o_sel        : [0:M-1][0:N-1] crossbar select, decoded from state flops only
//   o_grant      : [0:N-1] input n owns some output, decoded from state flops only
//
// state        | meaning
// ALLOC_IDLE   | output free; arbitrate among requesters starting at ptr
// ALLOC_LOCKED | output owned by owner_q; o_sel[m] = onehot(owner_q)
module lib_switch_allocator_onehot
    import lib_switch_allocator_onehot_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic [0:N-1][0:M-1]  i_req,
    input  logic [0:N-1]         i_tail,
    output logic [0:M-1][0:N-1]  o_sel,
    output logic [0:N-1]         o_grant
);

    localparam int PW = $clog2(N);

    logic [0:N-1][0:M-1] req_san;
    logic [0:M-1][0:N-1] col_req;
    logic [0:M-1][0:N-1] arb_gnt;

    alloc_state_t  state_q [M];
    alloc_state_t  state_d [M];
    logic [PW-1:0] owner_q [M];
    logic [PW-1:0] owner_d [M];
    logic [PW-1:0] ptr_q   [M];
    logic [PW-1:0] ptr_d   [M];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(N - 1)) ? '0 : v + 1'b1;
    endfunction

    // Keep only the lowest-index output per input, then transpose per output.
    always_comb begin
        logic taken;
        req_san = '0;
        col_req = '0;
        taken   = 1'b0;
        for (int n = 0; n < N; n++) begin
            taken = 1'b0;
            for (int m = 0; m < M; m++) begin
                if (i_req[n][m] && !taken) begin
                    req_san[n][m] = 1'b1;
                    taken         = 1'b1;
                end
            end
        end
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                col_req[m][n] = req_san[n][m];
            end
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .req (col_req[m]),
            .ptr (ptr_q[m]),
            .gnt (arb_gnt[m])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < M; m++) begin
                state_q[m] <= ALLOC_IDLE;
                owner_q[m] <= '0;
                ptr_q[m]   <= '0;
            end
        end else begin
            for (int m = 0; m < M; m++) begin
                state_q[m] <= state_d[m];
                owner_q[m] <= owner_d[m];
                ptr_q[m]   <= ptr_d[m];
            end
        end
    end

    // A locked output always passes through IDLE for one cycle on release,
    // so re-arbitration only ever happens from the IDLE state.
    always_comb begin
        alloc_vec_t gnt_w;
        logic       own_req;
        gnt_w   = '0;
        own_req = 1'b0;
        for (int m = 0; m < M; m++) begin
            state_d[m] = state_q[m];
            owner_d[m] = owner_q[m];
            ptr_d[m]   = ptr_q[m];
            gnt_w          = '0;
            gnt_w[0:N-1]   = arb_gnt[m];
            own_req        = req_san[owner_q[m]][m];
            if (ce) begin
                case (state_q[m])
                    ALLOC_IDLE: begin
                        if (|col_req[m]) begin
                            state_d[m] = ALLOC_LOCKED;
                            owner_d[m] = PW'(onehot_to_bin(gnt_w));
                        end
                    end
                    ALLOC_LOCKED: begin
                        // Abort on withdrawal, normal release on tail transfer.
                        if (!own_req || i_tail[owner_q[m]]) begin
                            state_d[m] = ALLOC_IDLE;
                            ptr_d[m]   = wrap_inc(owner_q[m]);
                        end
                    end
                    default: state_d[m] = ALLOC_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        o_sel   = '0;
        o_grant = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                o_sel[m][n] = (state_q[m] == ALLOC_LOCKED) && (owner_q[m] == PW'(n));
            end
        end
        for (int n = 0; n < N; n++) begin
            for (int m = 0; m < M; m++) begin
                o_grant[n] = o_grant[n] | o_sel[m][n];
            end
        end
    end

endmodule

// File: tb/tb_lib_switch_allocator_onehot.sv
// Testbench for lib_switch_allocator_onehot: vector table, hand sequences for
// lock/abort/ce/reset corner cases, and a randomized run against a behavioural model.
module tb_lib_switch_allocator_onehot;

    localparam int N = 4;
    localparam int M = 4;

    typedef logic [0:N-1][0:M-1] req_t;
    typedef logic [0:M-1][0:N-1] sel_t;
    typedef logic [0:N-1]        vec_t;

    typedef struct {
        logic  rst_before;
        req_t  req;
        vec_t  tail;
        logic  ce;
        sel_t  exp_sel;
        vec_t  exp_grant;
        string name;
    } vector_t;

    logic clk = 1'b0;
    logic reset_n;
    logic ce;
    req_t i_req;
    vec_t i_tail;
    sel_t o_sel;
    vec_t o_grant;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: owner index per output (-1 = idle) and RR pointer.
    int own [M];
    int ptr [M];

    always #5 clk = ~clk;

    lib_switch_allocator_onehot #(.N(N), .M(M)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .i_req   (i_req),
        .i_tail  (i_tail),
        .o_sel   (o_sel),
        .o_grant (o_grant)
    );

    task automatic check_sel(input string name, input sel_t got, input sel_t exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: o_sel got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_grant(input string name, input vec_t got, input vec_t exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: o_grant got %b expected %b", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            own[m] = -1;
            ptr[m] = 0;
        end
    endtask

    task automatic model_step(input req_t r, input vec_t t, input logic c);
        int san [N];
        if (!c) return;
        for (int n = 0; n < N; n++) begin
            san[n] = -1;
            for (int m = M - 1; m >= 0; m--) if (r[n][m]) san[n] = m;
        end
        for (int m = 0; m < M; m++) begin
            if (own[m] < 0) begin
                for (int k = 0; k < N; k++) begin
                    int cand;
                    cand = (ptr[m] + k) % N;
                    if (own[m] < 0 && san[cand] == m) own[m] = cand;
                end
            end else begin
                int o;
                o = own[m];
                if (san[o] != m || t[o]) begin
                    own[m] = -1;
                    ptr[m] = (o + 1) % N;
                end
            end
        end
    endtask

    function automatic sel_t model_sel();
        sel_t s;
        s = '0;
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++)
                s[m][n] = (own[m] == n);
        return s;
    endfunction

    function automatic vec_t model_grant();
        vec_t g;
        g = '0;
        for (int n = 0; n < N; n++)
            for (int m = 0; m < M; m++)
                if (own[m] == n) g[n] = 1'b1;
        return g;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        i_req   = '0;
        i_tail  = '0;
        ce      = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic apply(input req_t r, input vec_t t, input logic c);
        i_req  = r;
        i_tail = t;
        ce     = c;
        @(posedge clk);
        model_step(r, t, c);
        #1;
    endtask

    task automatic step_check(input string name, input req_t r, input vec_t t, input logic c,
                              input sel_t es, input vec_t eg);
        apply(r, t, c);
        check_sel(name, o_sel, es);
        check_grant(name, o_grant, eg);
    endtask

    vector_t tab [$];

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        i_req   = '0;
        i_tail  = '0;
        model_reset();

        // Contention: inputs 0,1,3 on output 2 with single-word packets.
        tab.push_back('{1'b1, 16'b0010_0010_0000_0010, 4'b1111, 1'b1, 16'b0000_0000_1000_0000, 4'b1000, "cont_own0"});
        tab.push_back('{1'b0, 16'b0010_0010_0000_0010, 4'b1111, 1'b1, 16'b0000_0000_0000_0000, 4'b0000, "cont_idle1"});
        tab.push_back('{1'b0, 16'b0010_0010_0000_0010, 4'b1111, 1'b1, 16'b0000_0000_0100_0000, 4'b0100, "cont_own1"});
        tab.push_back('{1'b0, 16'b0010_0010_0000_0010, 4'b1111, 1'b1, 16'b0000_0000_0000_0000, 4'b0000, "cont_idle2"});
        tab.push_back('{1'b0, 16'b0010_0010_0000_0010, 4'b1111, 1'b1, 16'b0000_0000_0001_0000, 4'b0001, "cont_own3"});
        tab.push_back('{1'b0, 16'b0010_0010_0000_0010, 4'b1111, 1'b1, 16'b0000_0000_0000_0000, 4'b0000, "cont_idle3"});
        tab.push_back('{1'b0, 16'b0010_0010_0000_0010, 4'b1111, 1'b1, 16'b0000_0000_1000_0000, 4'b1000, "cont_wrap0"});
        tab.push_back('{1'b0, 16'b0000_0000_0000_0000, 4'b0000, 1'b1, 16'b0000_0000_0000_0000, 4'b0000, "cont_end"});
        // Parallel locks plus sanitising of multi-bit requests.
        tab.push_back('{1'b1, 16'b0110_1000_0000_0000, 4'b0000, 1'b1, 16'b0100_1000_0000_0000, 4'b1100, "par_lock"});
        tab.push_back('{1'b0, 16'b0110_1000_0000_0000, 4'b0000, 1'b1, 16'b0100_1000_0000_0000, 4'b1100, "par_hold"});
        tab.push_back('{1'b0, 16'b0110_1000_0000_0000, 4'b1000, 1'b1, 16'b0100_0000_0000_0000, 4'b0100, "par_tail0"});
        tab.push_back('{1'b0, 16'b0110_1000_0000_0000, 4'b0000, 1'b1, 16'b0100_1000_0000_0000, 4'b1100, "par_regrant"});
        tab.push_back('{1'b0, 16'b0110_0011_0000_0000, 4'b0000, 1'b1, 16'b0000_1000_0100_0000, 4'b1100, "par_redirect"});

        foreach (tab[i]) begin
            if (tab[i].rst_before) do_reset();
            step_check(tab[i].name, tab[i].req, tab[i].tail, tab[i].ce, tab[i].exp_sel, tab[i].exp_grant);
        end

        // Reset held with random requests, then first grant latency, then async drop.
        reset_n = 1'b0;
        ce      = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            i_req  = req_t'($urandom);
            i_tail = vec_t'($urandom);
            @(posedge clk);
            #1;
            check_sel("reset_hold", o_sel, '0);
            check_grant("reset_hold", o_grant, '0);
        end
        @(negedge clk);
        i_req   = '0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        i_req = 16'b0000_0000_0100_0000;
        #1;
        check_grant("no_comb_path", o_grant, '0);
        step_check("first_grant", 16'b0000_0000_0100_0000, 4'b0000, 1'b1, 16'b0000_0010_0000_0000, 4'b0010);
        step_check("first_hold", 16'b0000_0000_0100_0000, 4'b0000, 1'b1, 16'b0000_0010_0000_0000, 4'b0010);
        #3;
        reset_n = 1'b0;
        #1;
        check_sel("async_reset_drop", o_sel, '0);
        check_grant("async_reset_drop", o_grant, '0);

        // Lock hold: input 2 sends 5 words on output 0 while input 1 waits.
        do_reset();
        step_check("hold_c0", 16'b0000_0000_1000_0000, 4'b0000, 1'b1, 16'b0010_0000_0000_0000, 4'b0010);
        for (int w = 1; w <= 5; w++) begin
            if (w < 5)
                step_check("hold_word", 16'b0000_1000_1000_0000, 4'b0000, 1'b1, 16'b0010_0000_0000_0000, 4'b0010);
            else
                step_check("hold_tail", 16'b0000_1000_1000_0000, 4'b0010, 1'b1, 16'b0000_0000_0000_0000, 4'b0000);
        end
        step_check("hold_next", 16'b0000_1000_0000_0000, 4'b0000, 1'b1, 16'b0100_0000_0000_0000, 4'b0100);

        // Abort: input 1 withdraws from output 3 at word 2; pointer then favours input 2.
        do_reset();
        step_check("abort_c0", 16'b0000_0001_0000_0000, 4'b0000, 1'b1, 16'b0000_0000_0000_0100, 4'b0100);
        step_check("abort_w1", 16'b0001_0001_0001_0000, 4'b0000, 1'b1, 16'b0000_0000_0000_0100, 4'b0100);
        step_check("abort_w2", 16'b0001_0000_0001_0000, 4'b0000, 1'b1, 16'b0000_0000_0000_0000, 4'b0000);
        step_check("abort_ptr", 16'b0001_0001_0001_0000, 4'b0000, 1'b1, 16'b0000_0000_0000_0010, 4'b0010);

        // ce gating mid-packet with toggling requests.
        do_reset();
        step_check("ce_c0", 16'b0000_0000_0000_0100, 4'b0000, 1'b1, 16'b0000_0001_0000_0000, 4'b0001);
        step_check("ce_w1", 16'b0000_0000_0000_0100, 4'b0000, 1'b1, 16'b0000_0001_0000_0000, 4'b0001);
        step_check("ce_off1", 16'b0000_0000_0000_0000, 4'b1111, 1'b0, 16'b0000_0001_0000_0000, 4'b0001);
        step_check("ce_off2", 16'b0100_0000_0000_1000, 4'b1111, 1'b0, 16'b0000_0001_0000_0000, 4'b0001);
        step_check("ce_off3", 16'b1111_1111_1111_1111, 4'b1111, 1'b0, 16'b0000_0001_0000_0000, 4'b0001);
        step_check("ce_resume", 16'b0000_0000_0000_0100, 4'b0000, 1'b1, 16'b0000_0001_0000_0000, 4'b0001);
        step_check("ce_tail", 16'b0000_0000_0000_0100, 4'b0001, 1'b1, 16'b0000_0000_0000_0000, 4'b0000);
        step_check("ce_wrap_ptr", 16'b0100_0000_0000_0100, 4'b0000, 1'b1, 16'b0000_1000_0000_0000, 4'b1000);

        // Randomized run against the model.
        do_reset();
        begin
            req_t r;
            vec_t t;
            r = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                for (int n = 0; n < N; n++) begin
                    if ($urandom_range(3) == 0) begin
                        int kind;
                        int tgt;
                        kind = $urandom_range(5);
                        tgt  = $urandom_range(M - 1);
                        if (kind < 2) r[n] = '0;
                        else if (kind < 5) for (int j = 0; j < M; j++) r[n][j] = (j == tgt);
                        else r[n] = 4'($urandom_range(15));
                    end
                    t[n] = ($urandom_range(2) == 0);
                end
                apply(r, t, ($urandom_range(7) != 0));
                check_sel("random_sel", o_sel, model_sel());
                check_grant("random_grant", o_grant, model_grant());
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
